phys_reg_free_list_ckpt: RTL and testbench

//  Parametrised, checkpointed physical-register free list; replaces the fixed single-column free list.

---
 rtl/core_types_pkg.sv | 15 +
 rtl/free_list_ckpt_table.sv | 73 +++++++
 rtl/phys_reg_free_list_ckpt.sv | 88 ++++++++
 tb/tb_phys_reg_free_list_ckpt.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: physical register tags, checkpoint columns and free-list pointers.
// Pointers carry one extra wrap bit so that full and empty can be told apart.
package core_types_pkg;
  localparam int NUM_PHYS_REGS          = 64;
  localparam int NUM_ARCH_REGS          = 32;
  localparam int CHECKPOINT_COLUMNS     = 4;
  localparam int LOG_CHECKPOINT_COLUMNS = $clog2(CHECKPOINT_COLUMNS);
  localparam int PHYS_REG_TAG_W         = $clog2(NUM_PHYS_REGS);
  localparam int FREE_LIST_DEPTH        = NUM_PHYS_REGS;
  localparam int LOG_FREE_LIST_DEPTH    = $clog2(FREE_LIST_DEPTH);

  typedef logic [PHYS_REG_TAG_W-1:0]         phys_reg_tag_t;
  typedef logic [LOG_CHECKPOINT_COLUMNS-1:0] checkpoint_column_t;
  typedef logic [LOG_FREE_LIST_DEPTH:0]      free_list_ptr_t;
endpackage

// File: rtl/free_list_ckpt_table.sv
// Circular table of saved free-list head pointers; saves/clears/restores take effect next cycle.
// Saves are refused while every column is live; restore and clear are never stalled.
module free_list_ckpt_table
  import core_types_pkg::*;
#(
  parameter int CKPT_COLS = CHECKPOINT_COLUMNS,
  parameter int PTR_W     = LOG_FREE_LIST_DEPTH + 1,
  localparam int LCC      = $clog2(CKPT_COLS)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             save_i,
  input  logic [PTR_W-1:0] save_ptr_i,
  input  logic             restore_i,
  input  logic [LCC-1:0]   restore_col_i,
  input  logic             clear_i,
  output logic [LCC-1:0]   save_col_o,
  output logic             full_o,
  output logic             restore_hit_o,
  output logic [PTR_W-1:0] restore_ptr_o
);
  logic [PTR_W-1:0]     ptr_q [CKPT_COLS];
  logic [CKPT_COLS-1:0] valid_q, valid_d;
  logic [LCC:0]         ck_head_q, ck_head_d, ck_tail_q, ck_tail_d, live_cnt;
  logic [LCC-1:0]       rst_off, age;
  logic                 clear_fire, save_fire;

  assign live_cnt      = ck_tail_q - ck_head_q;
  assign full_o        = (live_cnt == (LCC+1)'(CKPT_COLS));
  assign save_col_o    = ck_tail_q[LCC-1:0];
  assign restore_hit_o = restore_i && valid_q[restore_col_i];
  assign restore_ptr_o = ptr_q[restore_col_i];
  assign clear_fire    = clear_i && (live_cnt != '0);
  assign save_fire     = save_i && !restore_hit_o && !full_o;
  // Position of the restored column counted from the oldest live one.
  assign rst_off       = restore_col_i - ck_head_q[LCC-1:0];

  always_comb begin
    valid_d   = valid_q;
    ck_head_d = ck_head_q;
    ck_tail_d = ck_tail_q;
    age       = '0;
    if (restore_hit_o) begin
      for (int i = 0; i < CKPT_COLS; i++) begin
        age = LCC'(i) - ck_head_q[LCC-1:0];
        if (age >= rst_off) valid_d[i] = 1'b0;
      end
      // A same-cycle clear of the restored oldest column must leave the table empty.
      ck_tail_d = ck_head_q + {1'b0, rst_off} + (LCC+1)'(clear_fire && (rst_off == '0));
    end else if (save_fire) begin
      valid_d[save_col_o] = 1'b1;
      ck_tail_d           = ck_tail_q + (LCC+1)'(1);
    end
    if (clear_fire) begin
      valid_d[ck_head_q[LCC-1:0]] = 1'b0;
      ck_head_d                   = ck_head_q + (LCC+1)'(1);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q   <= '0;
      ck_head_q <= '0;
      ck_tail_q <= '0;
      for (int i = 0; i < CKPT_COLS; i++) ptr_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      ck_head_q <= ck_head_d;
      ck_tail_q <= ck_tail_d;
      if (save_fire) ptr_q[save_col_o] <= save_ptr_i;
    end
  end
endmodule

// File: rtl/phys_reg_free_list_ckpt.sv
// Checkpointed physical-register free list; head tag is combinational from state, updates in 1 cycle.
// Deq on empty is ignored; enq on full (without a same-cycle deq) is dropped and flags enq_overflow.
module phys_reg_free_list_ckpt
  import core_types_pkg::*;
#(
  parameter int NUM_PHYS_REGS = core_types_pkg::NUM_PHYS_REGS,
  parameter int NUM_ARCH_REGS = core_types_pkg::NUM_ARCH_REGS,
  parameter int DEPTH         = NUM_PHYS_REGS,
  parameter int CKPT_COLS     = CHECKPOINT_COLUMNS,
  localparam int PRW          = $clog2(NUM_PHYS_REGS),
  localparam int LD           = $clog2(DEPTH),
  localparam int LCC          = $clog2(CKPT_COLS)
) (
  input  logic           CLK,
  input  logic           nRST,
  input  logic           deq_req,
  output logic           deq_valid,
  output logic [PRW-1:0] deq_tag,
  input  logic           enq_valid,
  input  logic [PRW-1:0] enq_tag,
  input  logic           save_valid,
  output logic [LCC-1:0] save_column,
  output logic           ckpt_full,
  input  logic           restore_valid,
  input  logic [LCC-1:0] restore_column,
  input  logic           clear_valid,
  output logic [LD:0]    free_count,
  output logic           enq_overflow
);
  localparam int INIT_FREE = NUM_PHYS_REGS - NUM_ARCH_REGS;

  logic [PRW-1:0] fifo_q [DEPTH];
  logic [LD:0]    head_q, head_d, tail_q, tail_d, head_adv, restore_ptr, span;
  logic           overflow_q, empty, full, deq_fire, enq_fire, restore_hit;

  assign empty      = (head_q == tail_q);
  assign full       = (head_q[LD] != tail_q[LD]) && (head_q[LD-1:0] == tail_q[LD-1:0]);
  assign deq_valid  = !empty;
  assign deq_tag    = fifo_q[head_q[LD-1:0]];
  assign free_count = tail_q - head_q;
  assign enq_overflow = overflow_q;

  assign deq_fire = deq_req && !empty && !restore_hit;
  assign enq_fire = enq_valid && (!full || deq_fire);
  assign head_adv = head_q + (LD+1)'(deq_fire);
  assign tail_d   = tail_q + (LD+1)'(enq_fire);
  assign span     = tail_d - restore_ptr;

  always_comb begin
    head_d = head_adv;
    if (restore_hit) begin
      // Slots released since the save may have been refilled; never claim more than DEPTH.
      head_d = (span > (LD+1)'(DEPTH)) ? tail_d - (LD+1)'(DEPTH) : restore_ptr;
    end
  end

  free_list_ckpt_table #(
    .CKPT_COLS (CKPT_COLS),
    .PTR_W     (LD + 1)
  ) u_ckpt_table (
    .CLK           (CLK),
    .nRST          (nRST),
    .save_i        (save_valid),
    .save_ptr_i    (head_adv),
    .restore_i     (restore_valid),
    .restore_col_i (restore_column),
    .clear_i       (clear_valid),
    .save_col_o    (save_column),
    .full_o        (ckpt_full),
    .restore_hit_o (restore_hit),
    .restore_ptr_o (restore_ptr)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_q     <= '0;
      tail_q     <= (LD+1)'(INIT_FREE);
      overflow_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++)
        fifo_q[i] <= (i < INIT_FREE) ? PRW'(NUM_ARCH_REGS + i) : '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      if (enq_valid && !enq_fire) overflow_q <= 1'b1;
      if (enq_fire) fifo_q[tail_q[LD-1:0]] <= enq_tag;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// Scenario bench for the checkpointed free list; a tag queue holds the expected dequeue order.
// Inputs change 1 time unit after the rising edge, outputs are checked in the same window.
module tb_phys_reg_free_list_ckpt;
  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       deq_req, deq_valid, enq_valid, save_valid, ckpt_full;
  logic       restore_valid, clear_valid, enq_overflow;
  logic [5:0] deq_tag, enq_tag;
  logic [1:0] save_column, restore_column;
  logic [6:0] free_count;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] sb[$];
  logic [5:0] exp_tag;

  phys_reg_free_list_ckpt dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .deq_req        (deq_req),
    .deq_valid      (deq_valid),
    .deq_tag        (deq_tag),
    .enq_valid      (enq_valid),
    .enq_tag        (enq_tag),
    .save_valid     (save_valid),
    .save_column    (save_column),
    .ckpt_full      (ckpt_full),
    .restore_valid  (restore_valid),
    .restore_column (restore_column),
    .clear_valid    (clear_valid),
    .free_count     (free_count),
    .enq_overflow   (enq_overflow)
  );

  always #5 CLK = ~CLK;

  task automatic idle();
    deq_req = 0; enq_valid = 0; enq_tag = 0; save_valid = 0;
    restore_valid = 0; restore_column = 0; clear_valid = 0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    idle();
    nRST = 0;
    tick();
    nRST = 1;
    sb.delete();
    for (int i = 32; i < 64; i++) sb.push_back(6'(i));
  endtask

  task automatic deq_n(input int n);
    for (int i = 0; i < n; i++) begin
      deq_req = 1; tick();
      void'(sb.pop_front());
    end
    deq_req = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL reset_count got %0d exp 32", free_count); end
    checks++; if (deq_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %0b exp 1", deq_valid); end
    checks++; if (deq_tag !== 6'd32) begin errors++; $display("FAIL reset_tag got %0d exp 32", deq_tag); end
    checks++; if (save_column !== 2'd0) begin errors++; $display("FAIL reset_savecol got %0d exp 0", save_column); end
    checks++; if (ckpt_full !== 1'b0) begin errors++; $display("FAIL reset_ckfull got %0b exp 0", ckpt_full); end
    checks++; if (enq_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", enq_overflow); end
    deq_n(3);
    #2 nRST = 0;
    #1;
    checks++; if (free_count !== 7'd32 || deq_tag !== 6'd32) begin
      errors++; $display("FAIL async_reset got count %0d tag %0d exp 32 32", free_count, deq_tag);
    end
    nRST = 1;
    tick();
  endtask

  task automatic test_drain();
    do_reset();
    for (int i = 0; i < 32; i++) begin
      deq_req = 1;
      exp_tag = sb.pop_front();
      checks++; if (deq_valid !== 1'b1 || deq_tag !== exp_tag) begin
        errors++; $display("FAIL drain_tag[%0d] got v%0b tag %0d exp v1 tag %0d", i, deq_valid, deq_tag, exp_tag);
      end
      tick();
    end
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", deq_valid); end
    checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", free_count); end
    tick();
    deq_req = 0;
    checks++; if (free_count !== 7'd0) begin errors++; $display("FAIL deq_on_empty got %0d exp 0", free_count); end
  endtask

  task automatic test_enq_empty();
    enq_valid = 1; enq_tag = 6'd7; deq_req = 1;
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL no_bypass got %0b exp 0", deq_valid); end
    tick();
    idle();
    checks++; if (deq_valid !== 1'b1 || deq_tag !== 6'd7) begin
      errors++; $display("FAIL enq_empty_tag got v%0b tag %0d exp v1 tag 7", deq_valid, deq_tag);
    end
    checks++; if (free_count !== 7'd1) begin errors++; $display("FAIL enq_empty_count got %0d exp 1", free_count); end
  endtask

  task automatic test_restore();
    do_reset();
    deq_n(3);
    save_valid = 1;
    checks++; if (save_column !== 2'd0) begin errors++; $display("FAIL rs_savecol got %0d exp 0", save_column); end
    tick(); idle();
    deq_n(5);
    enq_valid = 1; enq_tag = 6'd40; tick(); idle();
    restore_valid = 1; restore_column = 2'd0; deq_req = 1;
    tick(); idle();
    checks++; if (deq_tag !== 6'd35) begin errors++; $display("FAIL rs_tag got %0d exp 35", deq_tag); end
    checks++; if (free_count !== 7'd30) begin errors++; $display("FAIL rs_count got %0d exp 30", free_count); end
  endtask

  task automatic test_ckpt_full();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      save_valid = 1;
      checks++; if (save_column !== 2'(i)) begin errors++; $display("FAIL full_savecol[%0d] got %0d exp %0d", i, save_column, i); end
      tick();
    end
    idle();
    checks++; if (ckpt_full !== 1'b1) begin errors++; $display("FAIL full_set got %0b exp 1", ckpt_full); end
    save_valid = 1; tick(); idle();
    checks++; if (ckpt_full !== 1'b1 || save_column !== 2'd0) begin
      errors++; $display("FAIL full_5th got full %0b col %0d exp 1 0", ckpt_full, save_column);
    end
    clear_valid = 1; tick(); idle();
    checks++; if (ckpt_full !== 1'b0 || save_column !== 2'd0) begin
      errors++; $display("FAIL full_clear got full %0b col %0d exp 0 0", ckpt_full, save_column);
    end
    save_valid = 1; tick(); idle();
    checks++; if (ckpt_full !== 1'b1) begin errors++; $display("FAIL full_refill got %0b exp 1", ckpt_full); end
  endtask

  task automatic test_restore_younger();
    do_reset();
    save_valid = 1; tick(); idle();
    deq_n(2);
    save_valid = 1; tick(); idle();
    deq_n(1);
    restore_valid = 1; restore_column = 2'd0; tick(); idle();
    checks++; if (free_count !== 7'd32 || deq_tag !== 6'd32) begin
      errors++; $display("FAIL ry_head got count %0d tag %0d exp 32 32", free_count, deq_tag);
    end
    checks++; if (save_column !== 2'd0 || ckpt_full !== 1'b0) begin
      errors++; $display("FAIL ry_cols got col %0d full %0b exp 0 0", save_column, ckpt_full);
    end
    deq_n(1);
    restore_valid = 1; restore_column = 2'd1; tick(); idle();
    checks++; if (free_count !== 7'd31 || deq_tag !== 6'd33) begin
      errors++; $display("FAIL ry_ignored got count %0d tag %0d exp 31 33", free_count, deq_tag);
    end
  endtask

  task automatic test_restore_clear();
    do_reset();
    deq_n(2);
    save_valid = 1; tick(); idle();
    deq_n(1);
    restore_valid = 1; restore_column = 2'd0; clear_valid = 1; tick(); idle();
    checks++; if (free_count !== 7'd30 || deq_tag !== 6'd34) begin
      errors++; $display("FAIL rc_head got count %0d tag %0d exp 30 34", free_count, deq_tag);
    end
    checks++; if (save_column !== 2'd1 || ckpt_full !== 1'b0) begin
      errors++; $display("FAIL rc_cols got col %0d full %0b exp 1 0", save_column, ckpt_full);
    end
    deq_n(1);
    restore_valid = 1; restore_column = 2'd0; tick(); idle();
    checks++; if (free_count !== 7'd29) begin errors++; $display("FAIL rc_cleared got %0d exp 29", free_count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      deq_req = 1; enq_valid = 1; enq_tag = 6'($urandom_range(63));
      exp_tag = sb.pop_front();
      sb.push_back(enq_tag);
      checks++; if (deq_tag !== exp_tag) begin errors++; $display("FAIL wrap_tag[%0d] got %0d exp %0d", i, deq_tag, exp_tag); end
      tick();
    end
    idle();
    checks++; if (free_count !== 7'd32) begin errors++; $display("FAIL wrap_count got %0d exp 32", free_count); end
    for (int i = 0; i < 32; i++) begin
      enq_valid = 1; enq_tag = 6'($urandom_range(63));
      sb.push_back(enq_tag);
      tick();
    end
    idle();
    checks++; if (free_count !== 7'd64 || enq_overflow !== 1'b0) begin
      errors++; $display("FAIL fill got count %0d ovf %0b exp 64 0", free_count, enq_overflow);
    end
    enq_valid = 1; enq_tag = 6'd5; tick(); idle();
    checks++; if (enq_overflow !== 1'b1 || free_count !== 7'd64) begin
      errors++; $display("FAIL overflow got ovf %0b count %0d exp 1 64", enq_overflow, free_count);
    end
    enq_valid = 1; enq_tag = 6'd9; deq_req = 1;
    exp_tag = sb.pop_front();
    sb.push_back(6'd9);
    checks++; if (deq_tag !== exp_tag) begin errors++; $display("FAIL full_pair_tag got %0d exp %0d", deq_tag, exp_tag); end
    tick(); idle();
    checks++; if (free_count !== 7'd64 || enq_overflow !== 1'b1) begin
      errors++; $display("FAIL full_pair got count %0d ovf %0b exp 64 1", free_count, enq_overflow);
    end
    for (int i = 0; i < 64; i++) begin
      deq_req = 1;
      exp_tag = sb.pop_front();
      checks++; if (deq_valid !== 1'b1 || deq_tag !== exp_tag) begin
        errors++; $display("FAIL final_drain[%0d] got v%0b tag %0d exp v1 tag %0d", i, deq_valid, deq_tag, exp_tag);
      end
      tick();
    end
    idle();
    checks++; if (deq_valid !== 1'b0) begin errors++; $display("FAIL final_empty got %0b exp 0", deq_valid); end
  endtask

  initial begin
    idle();
    test_reset();
    test_drain();
    test_enq_empty();
    test_restore();
    test_ckpt_full();
    test_restore_younger();
    test_restore_clear();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
